// File: rtl/risc_pkg.sv
// rtl/risc_pkg.sv - shared opcode constants and loader state encoding
package risc_pkg;

  localparam logic [5:0]  OP_HALT   = 6'b111111;
  localparam logic [31:0] HALT_WORD = {OP_HALT, 26'd0};

  // Loader mode FSM encoding; the debug/monitor logic decodes state_o with this
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_RUN    = 2'd2,
    ST_HALTED = 2'd3
  } ld_state_e;

endpackage

// File: rtl/imem_ram.sv
// rtl/imem_ram.sv - DEPTH x 32 instruction array, one sync write and one sync read port
module imem_ram #(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [31:0]       wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [31:0]       rdata_o
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;

  // Array write; contents intentionally survive reset
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Registered read that holds its value when not strobed
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)     rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - instruction memory with CODE (load) and EXECUTE (fetch) mode FSM
module imem_loader
  import risc_pkg::*;
#(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_req,
  input  logic            ld_valid,
  output logic            ld_ready,
  input  logic [31:0]     ld_data,
  input  logic            ld_last,
  input  logic            start,
  input  logic            hlt,
  input  logic            fetch_en,
  input  logic [31:0]     fetch_addr,
  output logic [31:0]     fetch_instr,
  output logic            core_run,
  output logic [ADDR_W:0] prog_len,
  output logic            ovf_err,
  output logic [1:0]      state_o
);

  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);

  ld_state_e       state_q, state_d;
  logic [ADDR_W:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0] prog_len_q, prog_len_d;
  logic            ovf_q, ovf_d;
  logic            run_q;
  logic            halt_sel_q, halt_sel_d;
  logic            wr_en;
  logic            rd_en;
  logic [31:0]     ram_rdata;

  // Mode sequencing, load write pointer and program length bookkeeping
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    prog_len_d = prog_len_q;
    ovf_d      = ovf_q;
    wr_en      = 1'b0;
    case (state_q)
      ST_IDLE, ST_HALTED: begin
        if (load_req) begin
          state_d  = ST_LOAD;
          wr_ptr_d = '0;
          ovf_d    = 1'b0;
        end else if (start && (state_q == ST_HALTED || prog_len_q != '0)) begin
          state_d = ST_RUN;
        end
      end
      ST_LOAD: begin
        if (ld_valid) begin
          if (wr_ptr_q < DEPTH_W) begin
            wr_en    = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
          end else begin
            ovf_d = 1'b1;
          end
          if (ld_last) begin
            state_d    = ST_IDLE;
            prog_len_d = wr_ptr_d;
          end
        end
      end
      ST_RUN: begin
        if (hlt) state_d = ST_HALTED;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Fetches are serviced only in RUN, including the cycle that raises hlt
  assign rd_en      = fetch_en && (state_q == ST_RUN);
  assign halt_sel_d = rd_en ? (fetch_addr >= {{(31-ADDR_W){1'b0}}, prog_len_q}) : halt_sel_q;

  // State and status registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      prog_len_q <= '0;
      ovf_q      <= 1'b0;
      run_q      <= 1'b0;
      halt_sel_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      prog_len_q <= prog_len_d;
      ovf_q      <= ovf_d;
      run_q      <= (state_d == ST_RUN);
      halt_sel_q <= halt_sel_d;
    end
  end

  imem_ram #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ram (
    .clk_i   (clk),
    .rst_i   (rst),
    .we_i    (wr_en),
    .waddr_i (wr_ptr_q[ADDR_W-1:0]),
    .wdata_i (ld_data),
    .re_i    (rd_en),
    .raddr_i (fetch_addr[ADDR_W-1:0]),
    .rdata_o (ram_rdata)
  );

  assign ld_ready    = (state_q == ST_LOAD);
  assign fetch_instr = halt_sel_q ? HALT_WORD : ram_rdata;
  assign core_run    = run_q;
  assign prog_len    = prog_len_q;
  assign ovf_err     = ovf_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - scoreboard bench for imem_loader (DEPTH 1024 and DEPTH 4 builds)
`timescale 1ns/100ps
module tb_imem_loader;

  localparam logic [31:0] HW = 32'hFC00_0000;
  localparam logic [31:0] W0 = 32'h0022_0005;
  localparam logic [31:0] W1 = 32'h0043_0007;
  localparam logic [31:0] W2 = 32'hFC00_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic load_req = 1'b0, load_req4 = 1'b0;
  logic start = 1'b0, start4 = 1'b0;
  logic ld_valid = 1'b0, ld_last = 1'b0;
  logic [31:0] ld_data = '0;
  logic hlt = 1'b0, fetch_en = 1'b0;
  logic [31:0] fetch_addr = '0;

  logic        ld_ready0, core_run0, ovf0;
  logic [31:0] fi0;
  logic [10:0] plen0;
  logic [1:0]  st0;
  logic        ld_ready4, core_run4, ovf4;
  logic [31:0] fi4;
  logic [2:0]  plen4;
  logic [1:0]  st4;

  int n_chk = 0;
  int n_fail = 0;

  logic exp0 = 1'b0, exp4 = 1'b0;
  logic pend0 = 1'b0, pend4 = 1'b0;
  logic [31:0] q0[$];
  logic [31:0] q4[$];

  always #5 clk = ~clk;

  imem_loader #(.DEPTH(1024), .ADDR_W(10)) dut0 (
    .clk(clk), .rst(rst), .load_req(load_req), .ld_valid(ld_valid), .ld_ready(ld_ready0),
    .ld_data(ld_data), .ld_last(ld_last), .start(start), .hlt(hlt), .fetch_en(fetch_en),
    .fetch_addr(fetch_addr), .fetch_instr(fi0), .core_run(core_run0), .prog_len(plen0),
    .ovf_err(ovf0), .state_o(st0)
  );

  imem_loader #(.DEPTH(4), .ADDR_W(2)) dut4 (
    .clk(clk), .rst(rst), .load_req(load_req4), .ld_valid(ld_valid), .ld_ready(ld_ready4),
    .ld_data(ld_data), .ld_last(ld_last), .start(start4), .hlt(hlt), .fetch_en(fetch_en),
    .fetch_addr(fetch_addr), .fetch_instr(fi4), .core_run(core_run4), .prog_len(plen4),
    .ovf_err(ovf4), .state_o(st4)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Monitor: capture which cycles carried a tracked fetch, compare on the following negedge
  always @(posedge clk) begin
    pend0 <= exp0;
    pend4 <= exp4;
  end

  always @(negedge clk) begin
    if (pend0) begin
      if (q0.size() == 0) chk("fetch0_queue_underflow", 32'd1, 32'd0);
      else chk("fetch_instr0", fi0, q0.pop_front());
    end
    if (pend4) begin
      if (q4.size() == 0) chk("fetch4_queue_underflow", 32'd1, 32'd0);
      else chk("fetch_instr4", fi4, q4.pop_front());
    end
  end

  task automatic fetch0(input logic [31:0] a, input logic [31:0] e);
    fetch_en = 1'b1; fetch_addr = a; exp0 = 1'b1; q0.push_back(e);
    cyc();
  endtask

  task automatic fetch4(input logic [31:0] a, input logic [31:0] e);
    fetch_en = 1'b1; fetch_addr = a; exp4 = 1'b1; q4.push_back(e);
    cyc();
  endtask

  task automatic fetch_off();
    fetch_en = 1'b0; exp0 = 1'b0; exp4 = 1'b0;
  endtask

  task automatic beat(input logic [31:0] d, input logic last);
    ld_valid = 1'b1; ld_data = d; ld_last = last;
    cyc();
    ld_valid = 1'b0; ld_last = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    cyc(); cyc();
    chk("rst_state", 32'(st0), 32'd0);
    chk("rst_ld_ready", 32'(ld_ready0), 32'd0);
    chk("rst_fetch_instr", fi0, 32'd0);
    chk("rst_core_run", 32'(core_run0), 32'd0);
    chk("rst_prog_len", 32'(plen0), 32'd0);
    chk("rst_ovf_err", 32'(ovf0), 32'd0);
    rst = 1'b0;
    cyc();

    // T1: three-beat load
    load_req = 1'b1;
    cyc();
    load_req = 1'b0;
    chk("t1_state_load", 32'(st0), 32'd1);
    chk("t1_ld_ready", 32'(ld_ready0), 32'd1);
    beat(W0, 1'b0);
    beat(W1, 1'b0);
    beat(W2, 1'b1);
    chk("t1_state_idle", 32'(st0), 32'd0);
    chk("t1_prog_len", 32'(plen0), 32'd3);
    chk("t1_ovf_err", 32'(ovf0), 32'd0);

    // T2: run and fetch across the program boundary
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("t2_state_run", 32'(st0), 32'd2);
    chk("t2_core_run", 32'(core_run0), 32'd1);
    fetch0(32'd0, W0);
    fetch0(32'd1, W1);
    fetch0(32'd2, W2);
    fetch0(32'd3, HW);
    fetch0(32'h0000_0400, HW);
    fetch0(32'h8000_0001, HW);
    fetch0(32'd0, W0);

    // T3: hlt with a same-cycle fetch, then resume
    hlt = 1'b1;
    fetch0(32'd1, W1);
    hlt = 1'b0;
    fetch_off();
    chk("t3_state_halted", 32'(st0), 32'd3);
    chk("t3_core_run_low", 32'(core_run0), 32'd0);
    fetch0(32'd0, W1);
    fetch_off();
    cyc();
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("t3_resume_state", 32'(st0), 32'd2);
    chk("t3_resume_core_run", 32'(core_run0), 32'd1);
    load_req = 1'b1;
    cyc();
    load_req = 1'b0;
    chk("t3_load_ignored_in_run", 32'(st0), 32'd2);
    hlt = 1'b1;
    cyc();
    hlt = 1'b0;
    chk("t3_halt_again", 32'(st0), 32'd3);

    // T6: load_req beats start in HALTED
    load_req = 1'b1; start = 1'b1;
    cyc();
    load_req = 1'b0; start = 1'b0;
    chk("t6_state_load", 32'(st0), 32'd1);
    chk("t6_ld_ready", 32'(ld_ready0), 32'd1);
    chk("t6_core_run", 32'(core_run0), 32'd0);
    beat(32'h1234_5678, 1'b1);
    chk("t6_state_idle", 32'(st0), 32'd0);
    chk("t6_prog_len", 32'(plen0), 32'd1);

    // T4: DEPTH=4 overflow
    load_req4 = 1'b1;
    cyc();
    load_req4 = 1'b0;
    beat(32'h11, 1'b0);
    beat(32'h22, 1'b0);
    beat(32'h33, 1'b0);
    beat(32'h44, 1'b0);
    chk("t4_ovf_before_full_beat", 32'(ovf4), 32'd0);
    beat(32'h55, 1'b0);
    beat(32'h66, 1'b1);
    chk("t4_state_idle", 32'(st4), 32'd0);
    chk("t4_prog_len", 32'(plen4), 32'd4);
    chk("t4_ovf_err", 32'(ovf4), 32'd1);
    chk("t4_dut0_untouched", 32'(plen0), 32'd1);
    start4 = 1'b1;
    cyc();
    start4 = 1'b0;
    fetch4(32'd0, 32'h11);
    fetch4(32'd1, 32'h22);
    fetch4(32'd2, 32'h33);
    fetch4(32'd3, 32'h44);
    fetch4(32'd4, HW);
    fetch4(32'd5, HW);
    fetch_off();
    cyc();

    // T5: async reset between posedges mid-load
    load_req = 1'b1;
    cyc();
    load_req = 1'b0;
    beat(32'hAAAA_0001, 1'b0);
    ld_valid = 1'b1; ld_data = 32'hAAAA_0002;
    cyc();
    ld_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("t5_state", 32'(st0), 32'd0);
    chk("t5_ld_ready", 32'(ld_ready0), 32'd0);
    chk("t5_prog_len", 32'(plen0), 32'd0);
    chk("t5_ovf_err", 32'(ovf0), 32'd0);
    chk("t5_core_run", 32'(core_run0), 32'd0);
    chk("t5_fetch_instr", fi0, 32'd0);
    chk("t5_dut4_prog_len", 32'(plen4), 32'd0);
    #2 rst = 1'b0;
    cyc();
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("t5_start_ignored_state", 32'(st0), 32'd0);
    chk("t5_start_ignored_run", 32'(core_run0), 32'd0);
    cyc();

    chk("scoreboard0_drained", 32'(q0.size()), 32'd0);
    chk("scoreboard4_drained", 32'(q4.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
